// File: rtl/imem_loader.sv
// Program loader: receives COUNT / N big-endian words / CHK over a valid/ready byte
// stream and writes the words into the instruction memory, holding the CPU meanwhile.
module imem_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [8:0] DEPTH_B = 9'(DEPTH);
  localparam logic [AW:0] ONE_W  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A = AW'(1);

  state_t        state_q, state_d;
  logic [AW:0]   n_q, n_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    xor_q, xor_d;
  logic          hold_q, hold_d;
  logic          err_q, err_d;
  logic [AW:0]   words_q, words_d;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    hi_d     = hi_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    xor_d    = xor_q;
    hold_d   = hold_q;
    err_d    = err_q;
    words_d  = words_q;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COUNT;
          err_d   = 1'b0;
          words_d = '0;
          xor_d   = '0;
          addr_d  = '0;
          hold_d  = 1'b1;
        end
      end
      S_COUNT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          xor_d = xor_q ^ in_data;
          n_d   = in_data[AW:0];
          if (in_data == '0 || {1'b0, in_data} > DEPTH_B) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hi_d    = in_data;
          xor_d   = xor_q ^ in_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wdata_d = {hi_q, in_data};
          xor_d   = xor_q ^ in_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we  = 1'b1;
        words_d = words_q + ONE_W;
        // address only advances when another word follows, so it never wraps
        if ({1'b0, addr_q} == n_q - ONE_W) begin
          state_d = S_CHK;
        end else begin
          addr_d  = addr_q + ONE_A;
          state_d = S_HI;
        end
      end
      S_CHK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if ((xor_q ^ in_data) == 8'h00) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
      end
      S_ERR: begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
        err_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      hi_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      xor_q   <= '0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      hi_q    <= hi_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      xor_q   <= xor_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_hold     = hold_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign error        = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued when a stream
// is sent and compared as mem_we pulses appear.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, cpu_hold, busy, done, error;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [4:0]  words_loaded;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int we_cnt    = 0;
  int done_cnt  = 0;

  logic [7:0]  stream[$];
  logic [19:0] exp_q[$];

  imem_loader #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        logic [19:0] e;
        we_cnt++;
        check("we_in_ready_low", 32'(in_ready), 32'd0);
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("waddr", 32'(mem_addr), 32'(e[19:16]));
          check("wdata", 32'(mem_wdata), 32'(e[15:0]));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_no_error", 32'(error), 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_err_clr"}, 32'(error), 32'd0);
    check({tag, "_words_clr"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic run_load(input string tag, input int gap);
    int n, w0, d0, t;
    bit legal, ok;
    logic [7:0] x;
    n     = int'(stream[0]);
    legal = (n >= 1 && n <= 16);
    x     = 8'h00;
    foreach (stream[i]) x = x ^ stream[i];
    ok = legal && (x == 8'h00);
    if (legal)
      for (int i = 0; i < n; i++)
        exp_q.push_back({4'(i), stream[1+2*i], stream[2+2*i]});
    w0 = we_cnt;
    d0 = done_cnt;
    do_start(tag);
    if (legal) begin
      foreach (stream[i]) send(stream[i], gap);
    end else begin
      send(stream[0], gap);
    end
    in_valid = 1'b0;
    t = 0;
    while (busy && t < 60) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done_cnt - d0), ok ? 32'd1 : 32'd0);
    check({tag, "_error"}, 32'(error), ok ? 32'd0 : 32'd1);
    check({tag, "_words"}, 32'(words_loaded), legal ? 32'(n) : 32'd0);
    check({tag, "_we_cnt"}, 32'(we_cnt - w0), legal ? 32'(n) : 32'd0);
    check({tag, "_hold_low"}, 32'(cpu_hold), 32'd0);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    int w0, t;
    logic [7:0] chk;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    stream = '{8'h04, 8'h80, 8'h84, 8'h81, 8'h06, 8'h11, 8'h60, 8'hA1, 8'h87, 8'hD0};
    run_load("nominal", 0);

    stream[9] = 8'hD1;
    run_load("badchk", 0);

    stream = '{8'h11};
    run_load("cnt17", 0);
    stream = '{8'h00};
    run_load("cnt0", 0);

    stream = '{8'h04, 8'h80, 8'h84, 8'h81, 8'h06, 8'h11, 8'h60, 8'hA1, 8'h87, 8'hD0};
    run_load("backpressure", 2);

    stream = '{8'h10};
    chk = 8'h10;
    for (int i = 0; i < 16; i++) begin
      stream.push_back(8'h00);
      stream.push_back(8'(i));
      chk = chk ^ 8'(i);
    end
    stream.push_back(chk);
    run_load("full", 0);

    // reset after the second write of a nominal stream
    exp_q.push_back({4'd0, 16'h8084});
    exp_q.push_back({4'd1, 16'h8106});
    w0 = we_cnt;
    do_start("midrst");
    send(8'h04, 0); send(8'h80, 0); send(8'h84, 0); send(8'h81, 0); send(8'h06, 0);
    in_valid = 1'b0;
    t = 0;
    while (we_cnt < w0 + 2 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("midrst_two_writes", 32'(we_cnt - w0), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);

    stream = '{8'h04, 8'h80, 8'h84, 8'h81, 8'h06, 8'h11, 8'h60, 8'hA1, 8'h87, 8'hD0};
    run_load("after_rst", 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
